// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and access geometry helper for the
// load/store unit and its lane-alignment datapath.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [15:0] HALT_ADDR_DEF = 16'hfffc;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        WAIT,
        RESP
    } state_t;

    // An access crosses a doubleword when offset plus byte count exceeds 8.
    function automatic logic is_split(input logic [2:0] f3, input logic [2:0] off);
        return ({1'b0, off} + (4'd1 << f3[1:0])) > 4'd8;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store shift with byte strobes, and
// load shift with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata0,
    input  logic [63:0] rdata1,
    output logic [63:0] wdata_lo,
    output logic [63:0] wdata_hi,
    output logic [7:0]  strb_lo,
    output logic [7:0]  strb_hi,
    output logic [63:0] ldata
);

    logic [7:0]   mask;
    logic [5:0]   sh;
    logic [127:0] wsh;
    logic [15:0]  strb;
    logic [63:0]  rsh;

    always_comb begin
        mask = 8'h00;
        unique case (funct3[1:0])
            2'b00: mask = 8'h01;
            2'b01: mask = 8'h03;
            2'b10: mask = 8'h0f;
            2'b11: mask = 8'hff;
        endcase
    end

    assign sh       = {off, 3'b000};
    assign wsh      = {64'b0, wdata} << sh;
    assign strb     = {8'b0, mask} << off;
    assign wdata_lo = wsh[63:0];
    assign wdata_hi = wsh[127:64];
    assign strb_lo  = strb[7:0];
    assign strb_hi  = strb[15:8];

    // Beat 1 sits above beat 0 so one right shift covers split loads.
    assign rsh = 64'({rdata1, rdata0} >> sh);

    always_comb begin
        ldata = 64'b0;
        unique case (funct3)
            F3_B:    ldata = {{56{rsh[7]}}, rsh[7:0]};
            F3_H:    ldata = {{48{rsh[15]}}, rsh[15:0]};
            F3_W:    ldata = {{32{rsh[31]}}, rsh[31:0]};
            F3_D:    ldata = rsh;
            F3_BU:   ldata = {56'b0, rsh[7:0]};
            F3_HU:   ldata = {48'b0, rsh[15:0]};
            F3_WU:   ldata = {32'b0, rsh[31:0]};
            default: ldata = 64'b0;
        endcase
    end

endmodule

// File: rtl/lsu_dm_port.sv
// RV64I load/store unit driving a doubleword-wide synchronous data
// memory, with split misaligned beats and a sticky halt-byte monitor.
module lsu_dm_port
    import lsu_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]   HALT_ADDR = ADDR_W'(HALT_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-4:0] mem_addr,
    output logic [7:0]        mem_wstrb,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic              halt
);

    localparam int HB_LSB = 8 * int'(HALT_ADDR[2:0]);

    state_t state, state_n;

    logic [2:0]        f3_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       rdata0_q;

    logic              illegal;
    logic              split;
    logic [ADDR_W-4:0] idx_lo;
    logic [ADDR_W-4:0] idx_hi;
    logic [63:0]       wdata_lo;
    logic [63:0]       wdata_hi;
    logic [7:0]        strb_lo;
    logic [7:0]        strb_hi;
    logic [63:0]       rd0;
    logic [63:0]       rd1;
    logic [63:0]       ldata;
    logic              halt_hit;
    logic              unused_addr;

    assign unused_addr = ^req_addr[63:ADDR_W];

    assign illegal = req_we ? (req_funct3 > F3_D)
                            : (req_funct3 == 3'b111);
    assign split   = is_split(f3_q, addr_q[2:0]);
    assign idx_lo  = addr_q[ADDR_W-1:3];
    assign idx_hi  = idx_lo + (ADDR_W-3)'(1);

    // In WAIT the bus carries beat 1 for split loads, else beat 0.
    assign rd0 = split ? rdata0_q : mem_rdata;
    assign rd1 = split ? mem_rdata : 64'b0;

    lsu_align u_align (
        .funct3   (f3_q),
        .off      (addr_q[2:0]),
        .wdata    (wdata_q),
        .rdata0   (rd0),
        .rdata1   (rd1),
        .wdata_lo (wdata_lo),
        .wdata_hi (wdata_hi),
        .strb_lo  (strb_lo),
        .strb_hi  (strb_hi),
        .ldata    (ldata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wstrb  = 8'b0;
        mem_wdata  = 64'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = illegal ? RESP : BEAT0;
            end
            BEAT0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = idx_lo;
                mem_wstrb = we_q ? strb_lo : 8'b0;
                mem_wdata = we_q ? wdata_lo : 64'b0;
                if (split)     state_n = BEAT1;
                else if (we_q) state_n = RESP;
                else           state_n = WAIT;
            end
            BEAT1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = idx_hi;
                mem_wstrb = we_q ? strb_hi : 8'b0;
                mem_wdata = we_q ? wdata_hi : 64'b0;
                state_n   = we_q ? RESP : WAIT;
            end
            WAIT: state_n = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign halt_hit = mem_req && mem_we
                   && (mem_addr == HALT_ADDR[ADDR_W-1:3])
                   && mem_wstrb[HALT_ADDR[2:0]]
                   && (mem_wdata[HB_LSB +: 8] == 8'hff);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_q       <= 3'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 64'b0;
            rdata0_q   <= 64'b0;
            resp_rdata <= 64'b0;
            resp_err   <= 1'b0;
            halt       <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                f3_q    <= req_funct3;
                we_q    <= req_we;
                addr_q  <= req_addr[ADDR_W-1:0];
                wdata_q <= req_wdata;
            end
            if (state == BEAT1 && !we_q) rdata0_q <= mem_rdata;
            resp_rdata <= (state == WAIT) ? ldata : 64'b0;
            resp_err   <= (state == IDLE) && req_valid && illegal;
            if (halt_hit) halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lsu_dm_port.sv
// Directed bench for lsu_dm_port with a doubleword synchronous memory
// model; every transaction goes through the DUT.
module tb_lsu_dm_port;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        halt;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [0:8191];

    logic [12:0] b_addr  [2];
    logic [7:0]  b_strb  [2];
    logic [63:0] b_wdata [2];
    int          nb;
    int          lat;
    int          wait_cyc;
    logic [63:0] rd;
    logic        er;

    lsu_dm_port dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd);
        int g;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        nb  = 0;
        lat = 0;
        g   = 0;
        while (!req_ready && g < 8) begin
            tick();
            g++;
        end
        wait_cyc = g;
        do begin
            tick();
            lat++;
            if (lat == 1) req_valid = 1'b0;
            if (mem_req) begin
                if (nb < 2) begin
                    b_addr[nb]  = mem_addr;
                    b_strb[nb]  = mem_wstrb;
                    b_wdata[nb] = mem_wdata;
                end
                nb++;
            end
        end while (!resp_valid && lat < 8);
        rd = resp_rdata;
        er = resp_err;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 64'b0;
        req_wdata  = 64'b0;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b0 || resp_valid !== 1'b0 || halt !== 1'b0
            || resp_rdata !== 64'b0 || resp_err !== 1'b0 || mem_wstrb !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: mem_req=%b resp_valid=%b halt=%b rdata=%h err=%b wstrb=%h expected all 0",
                     mem_req, resp_valid, halt, resp_rdata, resp_err, mem_wstrb);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_store_aligned;
        run_req(1'b1, F3_D, 64'h9000, 64'h8000_0001_1234_5678);
        chk("sd_aligned_lat", 64'(lat), 64'd2);
        chk("sd_aligned_beats", 64'(nb), 64'd1);
        chk("sd_aligned_addr", 64'(b_addr[0]), 64'h1200);
        chk("sd_aligned_strb", 64'(b_strb[0]), 64'hff);
        chk("sd_aligned_rdata", rd, 64'h0);
    endtask

    task automatic test_load_aligned;
        run_req(1'b0, F3_W, 64'h9004, 64'h0);
        chk("lw_lat", 64'(lat), 64'd3);
        chk("lw_beats", 64'(nb), 64'd1);
        chk("lw_addr", 64'(b_addr[0]), 64'h1200);
        chk("lw_rdata", rd, 64'hffff_ffff_8000_0001);
        chk("lw_err", 64'(er), 64'd0);
        run_req(1'b0, F3_B, 64'h9007, 64'h0);
        chk("lb_rdata", rd, 64'hffff_ffff_ffff_ff80);
        run_req(1'b0, F3_HU, 64'h9000, 64'h0);
        chk("lhu_aligned_rdata", rd, 64'h0000_0000_0000_5678);
    endtask

    task automatic test_split_load;
        run_req(1'b1, F3_B, 64'h9007, 64'hab);
        chk("sb_ab_strb", 64'(b_strb[0]), 64'h80);
        chk("sb_ab_lane", 64'(b_wdata[0][63:56]), 64'hab);
        run_req(1'b1, F3_B, 64'h9008, 64'hcd);
        chk("sb_cd_addr", 64'(b_addr[0]), 64'h1201);
        chk("sb_cd_strb", 64'(b_strb[0]), 64'h01);
        run_req(1'b0, F3_HU, 64'h9007, 64'h0);
        chk("lhu_split_lat", 64'(lat), 64'd4);
        chk("lhu_split_beats", 64'(nb), 64'd2);
        chk("lhu_split_addr0", 64'(b_addr[0]), 64'h1200);
        chk("lhu_split_addr1", 64'(b_addr[1]), 64'h1201);
        chk("lhu_split_rdata", rd, 64'h0000_0000_0000_cdab);
        run_req(1'b0, F3_H, 64'h9007, 64'h0);
        chk("lh_split_rdata", rd, 64'hffff_ffff_ffff_cdab);
    endtask

    task automatic test_split_store;
        run_req(1'b1, F3_D, 64'h9003, 64'h0102_0304_0506_0708);
        chk("sd_split_lat", 64'(lat), 64'd3);
        chk("sd_split_beats", 64'(nb), 64'd2);
        chk("sd_split_strb0", 64'(b_strb[0]), 64'hf8);
        chk("sd_split_strb1", 64'(b_strb[1]), 64'h07);
        chk("sd_split_addr0", 64'(b_addr[0]), 64'h1200);
        chk("sd_split_addr1", 64'(b_addr[1]), 64'h1201);
        chk("sd_split_wdata0", b_wdata[0], 64'h0405_0607_0800_0000);
        chk("sd_split_wdata1", b_wdata[1], 64'h0000_0000_0001_0203);
        run_req(1'b0, F3_D, 64'h9003, 64'h0);
        chk("ld_split_lat", 64'(lat), 64'd4);
        chk("ld_split_rdata", rd, 64'h0102_0304_0506_0708);
    endtask

    task automatic test_error;
        run_req(1'b0, 3'b111, 64'h9000, 64'h0);
        chk("err_load_lat", 64'(lat), 64'd1);
        chk("err_load_beats", 64'(nb), 64'd0);
        chk("err_load_flag", 64'(er), 64'd1);
        chk("err_load_rdata", rd, 64'h0);
        run_req(1'b1, 3'b100, 64'h9000, 64'hffff);
        chk("err_store_beats", 64'(nb), 64'd0);
        chk("err_store_flag", 64'(er), 64'd1);
        run_req(1'b1, F3_W, 64'h9000, 64'h0);
        chk("err_clear_after", 64'(er), 64'd0);
    endtask

    task automatic test_halt;
        run_req(1'b1, F3_B, 64'hfffc, 64'h7f);
        chk("halt7f_addr", 64'(b_addr[0]), 64'h1fff);
        chk("halt7f_strb", 64'(b_strb[0]), 64'h10);
        tick();
        chk("halt7f_no_halt", 64'(halt), 64'd0);
        run_req(1'b1, F3_B, 64'hfffc, 64'hff);
        chk("haltff_lane", 64'(b_wdata[0][39:32]), 64'hff);
        chk("haltff_set", 64'(halt), 64'd1);
        run_req(1'b1, F3_B, 64'hfffc, 64'h00);
        tick();
        tick();
        chk("halt_sticky", 64'(halt), 64'd1);
        run_req(1'b1, F3_B, 64'hfffc, 64'hff);
        run_req(1'b0, F3_BU, 64'hfffc, 64'h0);
        chk("halt_byte_written", rd, 64'hff);
    endtask

    task automatic test_back_to_back;
        run_req(1'b1, F3_W, 64'h0100, 64'hdead_beef);
        chk("b2b_sw_addr", 64'(b_addr[0]), 64'h0020);
        chk("b2b_sw_strb", 64'(b_strb[0]), 64'h0f);
        chk("b2b_resp_not_ready", 64'(req_ready), 64'd0);
        run_req(1'b0, F3_WU, 64'h0100, 64'h0);
        chk("b2b_gap", 64'(wait_cyc), 64'd1);
        chk("b2b_lwu_lat", 64'(lat), 64'd3);
        chk("b2b_lwu_rdata", rd, 64'h0000_0000_dead_beef);
    endtask

    task automatic test_reset_mid;
        int  g;
        logic found;
        req_we     = 1'b1;
        req_funct3 = F3_D;
        req_addr   = 64'h9003;
        req_wdata  = 64'h1111_2222_3333_4444;
        req_valid  = 1'b1;
        found = 1'b0;
        g = 0;
        while (!found && g < 10) begin
            tick();
            g++;
            if (!req_ready) req_valid = 1'b0;
            if (mem_req && mem_addr == 13'h1201) found = 1'b1;
        end
        req_valid = 1'b0;
        chk("rstmid_reached_beat1", 64'(found), 64'd1);
        rst = 1'b0;
        #1;
        chk("rstmid_mem_req_drop", 64'(mem_req), 64'd0);
        chk("rstmid_halt_clear", 64'(halt), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0 || halt !== 1'b0
            || resp_rdata !== 64'b0 || resp_err !== 1'b0 || mem_wstrb !== 8'b0
            || mem_wdata !== 64'b0) begin
            errors++;
            $display("FAIL rstmid_after_release: ready=%b resp_valid=%b mem_req=%b halt=%b rdata=%h err=%b expected ready=1 rest 0",
                     req_ready, resp_valid, mem_req, halt, resp_rdata, resp_err);
        end
    endtask

    initial begin
        test_reset();
        test_store_aligned();
        test_load_aligned();
        test_split_load();
        test_split_store();
        test_error();
        test_halt();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
